// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA sync timing plus four selectable test patterns (bars, checker, gradient, solid).
// Optional per-frame horizontal scroll of bars/checker is compiled in with VGA_PATTERN_SCROLL_EN.
module vga_pattern_gen #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned PIXEL_W     = 3,
  parameter int unsigned BAR_SHIFT   = 7,
  parameter int unsigned CHECK_SHIFT = 5,
  parameter int unsigned GRAD_SHIFT  = 6,
  localparam int unsigned H_TOTAL    = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int unsigned V_TOTAL    = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int unsigned CW         = $clog2(H_TOTAL),
  localparam int unsigned CH         = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] fg_color,
  output logic [PIXEL_W-1:0] pixel,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               in_display,
  output logic [CW-1:0]      counter_x,
  output logic [CH-1:0]      counter_y,
  output logic               frame_start
);

  localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  mode_e              amode;
  mode_e              amode_nxt;
  logic [CW-1:0]      x_nxt;
  logic [CH-1:0]      y_nxt;
  logic [CW-1:0]      scroll;
  logic [CW-1:0]      ex_c;
  logic               x_last_c;
  logic               y_last_c;
  logic               frame_last_c;
  logic               frame_first_c;
  logic               visible_c;
  logic               hs_active_c;
  logic               vs_active_c;
  logic [PIXEL_W-1:0] color_c;
  logic [PIXEL_W-1:0] pixel_nxt;

  // Position decodes shared by the counters, the mode latch and the output stage.
  always_comb begin
    x_last_c      = (counter_x == CW'(H_TOTAL - 1));
    y_last_c      = (counter_y == CH'(V_TOTAL - 1));
    frame_last_c  = x_last_c && y_last_c;
    frame_first_c = (counter_x == '0) && (counter_y == '0);
    visible_c     = (32'(counter_x) < H_VISIBLE) && (32'(counter_y) < V_VISIBLE);
    hs_active_c   = (32'(counter_x) >= HS_START) && (32'(counter_x) < HS_END);
    vs_active_c   = (32'(counter_y) >= VS_START) && (32'(counter_y) < VS_END);
  end

  // Counter advance; the pattern mode only changes between frames so a picture never tears.
  always_comb begin
    x_nxt     = counter_x + CW'(1);
    y_nxt     = counter_y;
    amode_nxt = amode;
    if (x_last_c) begin
      x_nxt = '0;
      y_nxt = y_last_c ? '0 : counter_y + CH'(1);
    end
    if (frame_last_c) begin
      amode_nxt = mode_e'(mode);
    end
  end

`ifdef VGA_PATTERN_SCROLL_EN
  // Scroll offset steps once per frame, on the same edge as the mode load.
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll <= '0;
    end else if (frame_last_c) begin
      scroll <= scroll + CW'(1);
    end
  end
`else
  assign scroll = '0;
`endif

  // Pattern colour for the current count; blanked outside the visible window.
  always_comb begin
    ex_c    = counter_x + scroll;
    color_c = '0;
    case (amode)
      MODE_BARS:  color_c = PIXEL_W'(ex_c >> BAR_SHIFT);
      MODE_CHECK: color_c = (ex_c[CHECK_SHIFT] ^ counter_y[CHECK_SHIFT]) ? fg_color : '0;
      MODE_GRAD:  color_c = PIXEL_W'(counter_y >> GRAD_SHIFT);
      MODE_SOLID: color_c = fg_color;
      default:    color_c = '0;
    endcase
    pixel_nxt = visible_c ? color_c : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter_x   <= '0;
      counter_y   <= '0;
      amode       <= MODE_BARS;
      pixel       <= '0;
      hsync_out   <= 1'b1;
      vsync_out   <= 1'b1;
      in_display  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      counter_x   <= x_nxt;
      counter_y   <= y_nxt;
      amode       <= amode_nxt;
      pixel       <= pixel_nxt;
      hsync_out   <= ~hs_active_c;
      vsync_out   <= ~vs_active_c;
      in_display  <= visible_c;
      frame_start <= frame_first_c;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: table-driven and sequence checks of vga_pattern_gen on a shrunken raster.
// Scaled timing: 184 clocks per line, 47 lines per frame, bars every 32 px, 8 px checker, gradient every 8 lines.
module tb_vga_pattern_gen;

  localparam int H_VISIBLE = 160, H_FRONT = 4, H_SYNC = 12, H_BACK = 8;
  localparam int V_VISIBLE = 40,  V_FRONT = 2, V_SYNC = 2,  V_BACK = 3;
  localparam int PIXEL_W = 3, BAR_SHIFT = 5, CHECK_SHIFT = 3, GRAD_SHIFT = 3;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int CW = $clog2(H_TOTAL);
  localparam int CH = $clog2(V_TOTAL);
  localparam int FRAME = H_TOTAL * V_TOTAL;
  localparam int HS_START = H_VISIBLE + H_FRONT;
  localparam int VS_START = V_VISIBLE + V_FRONT;
  localparam logic [6:0] RST_VEC = 7'b000_1100;

  logic               clk = 1'b0;
  logic               reset;
  logic [1:0]         mode;
  logic [PIXEL_W-1:0] fg_color;
  logic [PIXEL_W-1:0] pixel;
  logic               hsync_out, vsync_out, in_display, frame_start;
  logic [CW-1:0]      counter_x;
  logic [CH-1:0]      counter_y;

  vga_pattern_gen #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .PIXEL_W(PIXEL_W), .BAR_SHIFT(BAR_SHIFT), .CHECK_SHIFT(CHECK_SHIFT), .GRAD_SHIFT(GRAD_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .fg_color(fg_color),
    .pixel(pixel), .hsync_out(hsync_out), .vsync_out(vsync_out), .in_display(in_display),
    .counter_x(counter_x), .counter_y(counter_y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct { string name; int mode; logic [2:0] fg; int x; int y; logic [2:0] pix; logic de; } vec_t;
  typedef struct { string name; logic [6:0] v; } sb_t;

  vec_t tbl[$];
  sb_t  sbq[$];
  int   errors = 0, checks = 0;
  int   tx = 0, ty = 0, am = 0, sc = 0, px = 0, py = 0;
  bit   model_valid = 0, stats_on = 0;
  int   cyc = 0, last_fs = 0, last_period = 0, mism = 0, cmism = 0;
  int   hs_cnt = 0, hs_first = -1, hs_last = -1, vs_cnt = 0, vs_first = -1, vs_last = -1;

  task automatic check(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference output {pixel, hsync, vsync, in_display, frame_start} for a count position.
  function automatic logic [6:0] ref_out(int x, int y, int m, int s, logic [2:0] fg, logic rst);
    int ex;
    logic [2:0] p;
    logic vis, hs, vs, fs;
    if (rst) return RST_VEC;
    vis = (x < H_VISIBLE) && (y < V_VISIBLE);
    ex  = (x + s) % (1 << CW);
    case (m)
      0:       p = 3'((ex >> BAR_SHIFT) % 8);
      1:       p = ((((ex >> CHECK_SHIFT) ^ (y >> CHECK_SHIFT)) & 1) != 0) ? fg : 3'd0;
      2:       p = 3'((y >> GRAD_SHIFT) % 8);
      default: p = fg;
    endcase
    if (!vis) p = 3'd0;
    hs = !((x >= HS_START) && (x < HS_START + H_SYNC));
    vs = !((y >= VS_START) && (y < VS_START + V_SYNC));
    fs = (x == 0) && (y == 0);
    return {p, hs, vs, vis, fs};
  endfunction

  // One clock: predict, advance the model at the edge, then sample and compare every cycle.
  task automatic step();
    logic [6:0] e, got;
    logic r_rst;
    logic [1:0] r_mode;
    e = ref_out(tx, ty, am, sc, fg_color, reset);
    r_rst = reset;
    r_mode = mode;
    px = tx;
    py = ty;
    @(posedge clk);
    if (r_rst) begin
      tx = 0; ty = 0; am = 0; sc = 0; model_valid = 1;
    end else begin
      if (tx == H_TOTAL - 1 && ty == V_TOTAL - 1) begin
        am = int'(r_mode);
`ifdef VGA_PATTERN_SCROLL_EN
        sc = (sc + 1) % (1 << CW);
`endif
      end
      if (tx == H_TOTAL - 1) begin
        tx = 0;
        ty = (ty == V_TOTAL - 1) ? 0 : ty + 1;
      end else begin
        tx++;
      end
    end
    #1;
    cyc++;
    got = {pixel, hsync_out, vsync_out, in_display, frame_start};
    if (model_valid) begin
      if (got !== e) begin
        if (mism == 0) $display("first divergence: out for x=%0d y=%0d got %b exp %b", px, py, got, e);
        mism++;
      end
      if (int'(counter_x) != tx || int'(counter_y) != ty) cmism++;
    end
    if (frame_start === 1'b1) begin
      last_period = cyc - last_fs;
      last_fs = cyc;
    end
    if (stats_on) begin
      if (hsync_out === 1'b0 && py == 0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = px;
        hs_last = px;
      end
      if (vsync_out === 1'b0) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = py;
        vs_last = py;
      end
    end
  endtask

  task automatic check_next(string name, logic [6:0] expv);
    sb_t s;
    logic [6:0] got;
    s.name = name;
    s.v = expv;
    sbq.push_back(s);
    step();
    s = sbq.pop_front();
    got = {pixel, hsync_out, vsync_out, in_display, frame_start};
    checks++;
    if (got !== s.v) begin
      errors++;
      $display("FAIL %s: got {pix,hs,vs,de,fs}=%b expected %b", s.name, got, s.v);
    end
  endtask

  task automatic run_to(int x, int y);
    int n = 0;
    while (!(tx == x && ty == y) && n < 2 * FRAME) begin
      step();
      n++;
    end
    if (!(tx == x && ty == y)) check("run_to_budget", n, 0);
  endtask

  function automatic void add_vec(string n, int m, logic [2:0] fg, int x, int y, logic [2:0] p, logic de);
    vec_t v;
    v.name = n; v.mode = m; v.fg = fg; v.x = x; v.y = y; v.pix = p; v.de = de;
    tbl.push_back(v);
  endfunction

  initial begin
    vec_t r;
    logic [6:0] e;

    add_vec("chk_0_0",      1, 3'd5,   0,  0, 3'd0, 1'b1);
    add_vec("chk_8_0",      1, 3'd5,   8,  0, 3'd5, 1'b1);
    add_vec("chk_160_0",    1, 3'd5, 160,  0, 3'd0, 1'b0);
    add_vec("chk_0_8",      1, 3'd5,   0,  8, 3'd5, 1'b1);
    add_vec("chk_8_8",      1, 3'd5,   8,  8, 3'd0, 1'b1);
    add_vec("chk_159_39",   1, 3'd5, 159, 39, 3'd5, 1'b1);
    add_vec("grad_y0",      2, 3'd0,   5,  0, 3'd0, 1'b1);
    add_vec("grad_y8",      2, 3'd0,   5,  8, 3'd1, 1'b1);
    add_vec("grad_y17",     2, 3'd0, 100, 17, 3'd2, 1'b1);
    add_vec("grad_y39",     2, 3'd0, 159, 39, 3'd4, 1'b1);
    add_vec("grad_y40",     2, 3'd0,   0, 40, 3'd0, 1'b0);
    add_vec("bar_x0",       0, 3'd0,   0,  0, 3'd0, 1'b1);
    add_vec("bar_x31",      0, 3'd0,  31,  0, 3'd0, 1'b1);
    add_vec("bar_x32",      0, 3'd0,  32,  0, 3'd1, 1'b1);
    add_vec("bar_x159",     0, 3'd0, 159,  0, 3'd4, 1'b1);
    add_vec("bar_x160",     0, 3'd0, 160,  0, 3'd0, 1'b0);
    add_vec("bar_x100_y5",  0, 3'd0, 100,  5, 3'd3, 1'b1);

    // Reset held three cycles with a non-zero mode request.
    reset = 1'b1; mode = 2'd2; fg_color = 3'd0;
    for (int i = 0; i < 3; i++) check_next("reset_outputs", RST_VEC);
    check("reset_counters", int'({counter_x, counter_y}), 0);

    // First frame: sync timing, frame strobe, and amode still bars.
    reset = 1'b0;
    stats_on = 1;
    check_next("release_first_pixel", 7'b000_1111);
    run_to(32, 0);
    check_next("amode_stays_bars", 7'b001_1110);
    mode = 2'd1;
    run_to(0, 0);
    stats_on = 0;
    check("hsync_low_cycles", hs_cnt, H_SYNC);
    check("hsync_first_x", hs_first, HS_START);
    check("hsync_last_x", hs_last, HS_START + H_SYNC - 1);
    check("vsync_low_cycles", vs_cnt, V_SYNC * H_TOTAL);
    check("vsync_first_y", vs_first, VS_START);
    check("vsync_last_y", vs_last, VS_START + V_SYNC - 1);

    foreach (tbl[i]) begin
      r = tbl[i];
      if (r.mode != am) begin
        mode = 2'(r.mode);
        run_to(H_TOTAL - 1, V_TOTAL - 1);
        step();
      end
      run_to(r.x, r.y);
      fg_color = r.fg;
      e = ref_out(tx, ty, am, sc, fg_color, reset);
`ifndef VGA_PATTERN_SCROLL_EN
      e[6:4] = r.pix;
      e[1] = r.de;
`endif
      check_next(r.name, e);
    end
    check("frame_period", last_period, FRAME);

    // Mode request mid-frame must wait for the frame boundary.
    mode = 2'd3; fg_color = 3'd7;
    run_to(40, 20);
    check_next("no_tear_bar_y20", 7'b001_1110);
    run_to(100, 39);
    check_next("no_tear_bar_y39", 7'b011_1110);
    run_to(0, 0);
    check_next("solid_first_pixel", 7'b111_1111);
    run_to(10, 10);
    fg_color = 3'd2;
    check_next("solid_fg_live_a", 7'b010_1110);
    fg_color = 3'd6;
    check_next("solid_fg_live_b", 7'b110_1110);
    run_to(170, 10);
    check_next("solid_in_hsync", 7'b000_0100);

    // Mid-frame reset, then restart at pixel (0,0) with amode back to bars.
    run_to(0, 30);
    reset = 1'b1;
    check_next("midreset_a", RST_VEC);
    check("midreset_counters", int'({counter_x, counter_y}), 0);
    check_next("midreset_b", RST_VEC);
    reset = 1'b0;
    mode = 2'd0;
    check_next("midreset_restart", 7'b000_1111);
    run_to(31, 0);
    check_next("restart_bar_x31", 7'b000_1110);
    check_next("restart_bar_x32", 7'b001_1110);

`ifdef VGA_PATTERN_SCROLL_EN
    // Second frame after reset: bar edge moves one pixel left.
    run_to(30, 0);
    check_next("scroll_bar_x30", 7'b000_1110);
    check_next("scroll_bar_x31", 7'b001_1110);
`endif

    check("model_every_cycle", mism, 0);
    check("counters_every_cycle", cmism, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Parametrised VGA timing and test-pattern generator. It produces hsync, vsync and a registered pixel colour from one pixel clock, and supports four selectable patterns: colour bars, checkerboard, vertical gradient and solid colour. It sits directly at the VGA output pins and replaces the fixed colour-bar demo top. Its exported counters and frame strobe let later rendering blocks reuse its timing.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- PIXEL_W, 3, colour bits per pixel
- BAR_SHIFT, 7, x right-shift used for bar index
- CHECK_SHIFT, 5, log2 of checker square size
- GRAD_SHIFT, 6, y right-shift used for gradient

Ports:
- clk  input  1  pixel clock; all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- mode  input  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
- fg_color  input  PIXEL_W  colour used by mode 3 and by checker "on" squares
- pixel  output  PIXEL_W  registered colour
- hsync_out  output  1  registered hsync, active-low
- vsync_out  output  1  registered vsync, active-low
- in_display  output  1  registered; high when pixel carries a visible pixel
- counter_x  output  CW  current horizontal count, CW = $clog2(H_TOTAL)
- counter_y  output  CH  current vertical count, CH = $clog2(V_TOTAL)
- frame_start  output  1  one-cycle pulse, aligned with output of pixel (0,0)

## Operation
- H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800 by default). V_TOTAL is the vertical equivalent (525 by default).
- counter_x counts 0..H_TOTAL-1 and wraps to 0. On wrap, counter_y increments; counter_y wraps to 0 after V_TOTAL-1.
- Sync active region, horizontal: H_VISIBLE+H_FRONT ≤ x < H_VISIBLE+H_FRONT+H_SYNC. Vertical uses the same form with V_* values.
- Visible region: x < H_VISIBLE and y < V_VISIBLE.
- Active mode register (amode):
  - Loads `mode` only on the frame's last count (x=H_TOTAL-1, y=V_TOTAL-1).
  - A mid-frame change never tears the picture.
- Effective x, ex = (counter_x + scroll) mod 2^CW. scroll is 0 unless the scroll feature is compiled in.
- Colour per amode, used only when visible; otherwise pixel = 0:
  - 0: (ex >> BAR_SHIFT) truncated to PIXEL_W.
  - 1: fg_color if ex[CHECK_SHIFT] ^ y[CHECK_SHIFT], else 0.
  - 2: (y >> GRAD_SHIFT) truncated to PIXEL_W.
  - 3: fg_color.
- Arithmetic is unsigned, with truncation to the destination width.

## Timing
- counter_x and counter_y are registers. pixel, hsync_out, vsync_out, in_display and frame_start are registered from them.
- All outputs are therefore exactly one cycle behind the counters and mutually aligned.
- frame_start is high on the cycle after the counters are at (0,0).
- fg_color is sampled in the same cycle the colour is computed, with no frame latching.
- Reset values, on the first edge with reset high:
  - counters 0, amode 0, scroll 0
  - pixel 0, hsync_out 1, vsync_out 1, in_display 0, frame_start 0
- Reset mid-frame: on the next edge the counters are 0 and all outputs take their reset values. The cycle after reset deasserts outputs pixel (0,0), with frame_start=1.
- mode sampled with reset high is ignored; amode stays 0.
- Frame period: H_TOTAL*V_TOTAL clocks (420000 by default).

## Configuration
- VGA_PATTERN_SCROLL_EN defined:
  - A scroll register of width CW advances by 1 at each frame end, at the same edge as the amode load, and wraps mod 2^CW.
  - Modes 0 and 1 move left one pixel per frame.
- VGA_PATTERN_SCROLL_EN undefined: the scroll register is absent, scroll is the constant 0 and ex = counter_x.

## Test plan
- Reset check: hold reset 3 cycles with mode=2 → pixel=0, hsync_out=1, vsync_out=1, in_display=0, frame_start=0, counters 0. After release, amode stays 0 (bars).
- Hsync timing, defaults, y=0: hsync_out=0 on output cycles for x=656..751 inclusive (96 cycles) and 1 elsewhere. vsync_out=0 for lines 490..491 only.
- Bars, mode 0, scroll off: outputs for x=0, 127, 128, 639 → pixel 0, 0, 1, 4. Output for x=640 → pixel 0 and in_display=0.
- Checker: mode 1, fg_color=3'b101. Pixel (32,0) → 5; pixel (32,32) → 0; pixel (0,0) → 0.
- Frame-boundary mode change: switch mode 0→3 at y=100 with fg_color=7. Remainder of frame stays bars. The first pixel after frame_start is 7.
- Frame strobe and mid-frame reset:
  - frame_start pulses exactly every 420000 cycles.
  - Reset asserted at y=300 → the next frame_start comes 1 cycle after reset deasserts.
  - With VGA_PATTERN_SCROLL_EN, the bar boundary moves from x=128 to x=127 in the second frame.
